// File: rtl/memcopy_pkg.sv
// Shared types and default sizing for the word-serial memory copy engine.
package memcopy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int ADDR_STEP_DEF   = 4;
    localparam int COUNT_WIDTH_DEF = 16;

endpackage

// File: rtl/memory_copy_engine.sv
// Bus master copying a block of 32-bit words, one read then one write per word,
// against a memory with combinational read and synchronous write.
//
// state | meaning
// IDLE  | waiting for start; memory port holds last address
// READ  | source address on bus, read data captured at edge
// WRITE | destination address on bus with write strobe
// DONE  | one-cycle completion pulse, then back to IDLE
module memory_copy_engine
    import memcopy_pkg::*;
#(
    parameter int ADDR_STEP   = ADDR_STEP_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            srcBase,
    input  logic [31:0]            dstBase,
    input  logic [COUNT_WIDTH-1:0] wordCount,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [COUNT_WIDTH-1:0] wordsDone,
    output logic [31:0]            memAddress,
    output logic                   memWriteEnable,
    output logic [31:0]            memWriteData,
    input  logic [31:0]            memReadData
);

    localparam logic [31:0]            ADDR_INC = 32'(ADDR_STEP);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

    state_e                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic [31:0]            buf_q, buf_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic                   mem_we_q, mem_we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        words_d    = words_q;
        buf_d      = buf_q;
        mem_addr_d = mem_addr_q;
        aborted_d  = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d     = srcBase;
                    dst_d     = dstBase;
                    count_d   = wordCount;
                    words_d   = CNT_ZERO;
                    aborted_d = 1'b0;
                    if (wordCount == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_READ;
                        mem_addr_d = srcBase;
                    end
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else begin
                    buf_d      = memReadData;
                    src_d      = src_q + ADDR_INC;
                    mem_addr_d = dst_q;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The write in this cycle commits even when abort is raised.
                dst_d   = dst_q + ADDR_INC;
                words_d = words_q + CNT_ONE;
                if (abort || (words_q + CNT_ONE == count_q)) begin
                    state_d   = ST_DONE;
                    aborted_d = aborted_q | abort;
                end else begin
                    state_d    = ST_READ;
                    mem_addr_d = src_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        mem_we_d = (state_d == ST_WRITE);
        done_d   = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            words_q    <= '0;
            buf_q      <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            words_q    <= words_d;
            buf_q      <= buf_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign wordsDone      = words_q;
    assign memAddress     = mem_addr_q;
    assign memWriteEnable = mem_we_q;
    assign memWriteData   = buf_q;

endmodule

// File: tb/tb_memory_copy_engine.sv
// Directed bench for memory_copy_engine with a small word memory as responder.
module tb_memory_copy_engine;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic        abort;
    logic [31:0] srcBase;
    logic [31:0] dstBase;
    logic [15:0] wordCount;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] wordsDone;
    logic [31:0] memAddress;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    logic [31:0] mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] addr_log [0:63];

    int checks = 0;
    int failures = 0;
    int done_at;
    int nwrites;

    always #5 clk = ~clk;

    memory_copy_engine dut (
        .clk(clk), .resetN(resetN), .start(start), .abort(abort),
        .srcBase(srcBase), .dstBase(dstBase), .wordCount(wordCount),
        .busy(busy), .done(done), .aborted(aborted), .wordsDone(wordsDone),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memWriteData(memWriteData), .memReadData(memReadData)
    );

    // Memory responder: combinational read, synchronous write, 64 words.
    assign memReadData = mem[memAddress[7:2]];
    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddress[7:2]] <= memWriteData;
        else if (pl_we)     mem[pl_idx] <= pl_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_idx = 6'(idx); pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    // Start in cycle 0, then step cycles until done (bounded), returning at the
    // negedge of the done cycle. start/abort stay as driven in that cycle.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] cnt, input int abort_at,
                            input int rs_a, input int rs_b,
                            output int d_at, output int nw);
        d_at = -1; nw = 0;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0;
        srcBase = src; dstBase = dst; wordCount = cnt;
        @(negedge clk);
        for (int c = 1; c < 64 && d_at < 0; c++) begin
            @(posedge clk); #1;
            start = (c == rs_a) || (c == rs_b);
            abort = (c == abort_at);
            @(negedge clk);
            addr_log[c] = memAddress;
            if (memWriteEnable) nw++;
            if (done) d_at = c;
        end
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; abort = 1'b0;
        srcBase = '0; dstBase = '0; wordCount = '0;
        pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        for (int i = 0; i < 64; i++) addr_log[i] = '0;
        #2;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_we", 32'(memWriteEnable), 32'd0);
        check_val("rst_addr", memAddress, 32'd0);
        check_val("rst_wdata", memWriteData, 32'd0);
        check_val("rst_words", 32'(wordsDone), 32'd0);
        for (int i = 0; i < 64; i++) preload(i, 32'h0);
        resetN = 1'b1;
        preload(0, 32'h11111111);
        preload(1, 32'h22222222);
        preload(2, 32'h33333333);
        preload(3, 32'h44444444);
        preload(34, 32'hDEADBEEF);

        // Basic four-word copy to 0x40.
        run_xfer(32'h0, 32'h40, 16'd4, -1, -1, -1, done_at, nwrites);
        check_val("t1_done_cyc", 32'(done_at), 32'd9);
        check_val("t1_nwrites", 32'(nwrites), 32'd4);
        check_val("t1_words", 32'(wordsDone), 32'd4);
        check_val("t1_aborted", 32'(aborted), 32'd0);
        check_val("t1_busy_done", 32'(busy), 32'd1);
        check_val("t1_addr_c1", addr_log[1], 32'h0);
        check_val("t1_addr_c2", addr_log[2], 32'h40);
        check_val("t1_addr_c8", addr_log[8], 32'h4C);
        check_val("t1_m40", mem[16], 32'h11111111);
        check_val("t1_m44", mem[17], 32'h22222222);
        check_val("t1_m48", mem[18], 32'h33333333);
        check_val("t1_m4c", mem[19], 32'h44444444);
        idle_cycle();
        @(negedge clk);
        check_val("t1_idle_busy", 32'(busy), 32'd0);
        check_val("t1_idle_done", 32'(done), 32'd0);
        check_val("t1_idle_addr", memAddress, 32'h4C);

        // Zero-length request.
        run_xfer(32'h0, 32'h80, 16'd0, -1, -1, -1, done_at, nwrites);
        check_val("t2_done_cyc", 32'(done_at), 32'd1);
        check_val("t2_nwrites", 32'(nwrites), 32'd0);
        check_val("t2_words", 32'(wordsDone), 32'd0);
        idle_cycle();

        // Abort during the write of word 1.
        run_xfer(32'h0, 32'h80, 16'd4, 4, -1, -1, done_at, nwrites);
        check_val("t3_done_cyc", 32'(done_at), 32'd5);
        check_val("t3_words", 32'(wordsDone), 32'd2);
        check_val("t3_aborted", 32'(aborted), 32'd1);
        check_val("t3_m80", mem[32], 32'h11111111);
        check_val("t3_m84", mem[33], 32'h22222222);
        check_val("t3_m88", mem[34], 32'hDEADBEEF);
        idle_cycle();
        @(negedge clk);
        check_val("t3_aborted_held", 32'(aborted), 32'd1);

        // Start pulses while busy and on the done cycle are ignored.
        run_xfer(32'h0, 32'hC0, 16'd4, -1, 3, 9, done_at, nwrites);
        check_val("t4_done_cyc", 32'(done_at), 32'd9);
        check_val("t4_nwrites", 32'(nwrites), 32'd4);
        check_val("t4_aborted_clr", 32'(aborted), 32'd0);
        run_xfer(32'h4, 32'hD0, 16'd1, -1, -1, -1, done_at, nwrites);
        check_val("t4_restart_done", 32'(done_at), 32'd3);
        check_val("t4_restart_m", mem[52], 32'h22222222);
        check_val("t4_m_cc", mem[51], 32'h44444444);
        idle_cycle();

        // Overlapping ranges propagate word 0 forward.
        preload(0, 32'h0000000A);
        run_xfer(32'h0, 32'h4, 16'd3, -1, -1, -1, done_at, nwrites);
        check_val("t5_done_cyc", 32'(done_at), 32'd7);
        check_val("t5_m4", mem[1], 32'h0000000A);
        check_val("t5_m8", mem[2], 32'h0000000A);
        check_val("t5_mc", mem[3], 32'h0000000A);
        idle_cycle();

        // Source address wraps past 0xFFFFFFFC.
        preload(63, 32'h5555AAAA);
        run_xfer(32'hFFFFFFFC, 32'h120, 16'd2, -1, -1, -1, done_at, nwrites);
        check_val("t6_done_cyc", 32'(done_at), 32'd5);
        check_val("t6_addr_c1", addr_log[1], 32'hFFFFFFFC);
        check_val("t6_addr_c3", addr_log[3], 32'h0);
        check_val("t6_addr_c4", addr_log[4], 32'h124);
        check_val("t6_m120", mem[8], 32'h5555AAAA);
        check_val("t6_m124", mem[9], 32'h0000000A);
        idle_cycle();

        // Asynchronous reset in cycle 3 of a four-word copy.
        @(posedge clk); #1;
        start = 1'b1; srcBase = 32'h0; dstBase = 32'hA0; wordCount = 16'd4;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        check_val("t7_busy", 32'(busy), 32'd0);
        check_val("t7_we", 32'(memWriteEnable), 32'd0);
        check_val("t7_addr", memAddress, 32'd0);
        check_val("t7_wdata", memWriteData, 32'd0);
        check_val("t7_words", 32'(wordsDone), 32'd0);
        nwrites = 0; done_at = -1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) resetN = 1'b1;
            @(negedge clk);
            if (memWriteEnable) nwrites++;
            if (done) done_at = c;
        end
        check_val("t7_no_done", 32'(done_at), 32'hFFFFFFFF);
        check_val("t7_no_writes", 32'(nwrites), 32'd0);
        check_val("t7_ma0", mem[40], 32'h0000000A);
        check_val("t7_ma4", mem[41], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
